vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator with pixel-pipeline latency compensation.

---
 rtl/vga_timing_gen_if.sv | 42 ++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator.
// master: the timing generator (drives coordinates, strobes, sync and colour; samples PIXEL_DATA).
// slave : the pixel source / display side (drives PIXEL_DATA; observes everything else).
//   PIXEL_DATA   packed {R,G,B} colour returned for an earlier coordinate request
//   POS_X/POS_Y  request coordinates, undelayed
//   REQ_EN       request coordinates lie in the active area, undelayed
//   LINE_START   pulse at column 0, undelayed
//   FRAME_START  pulse at (0,0), undelayed
//   HSYNC/VSYNC  delayed sync at the configured polarity
//   DISPLAY_EN   delayed active-area flag, aligned with R/G/B
//   R/G/B        registered colour, zero outside the active area
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned R_W   = 3,
    parameter int unsigned G_W   = 3,
    parameter int unsigned B_W   = 2
);
    logic [R_W+G_W+B_W-1:0] PIXEL_DATA;
    logic [CNT_W-1:0]       POS_X;
    logic [CNT_W-1:0]       POS_Y;
    logic                   REQ_EN;
    logic                   LINE_START;
    logic                   FRAME_START;
    logic                   HSYNC;
    logic                   VSYNC;
    logic                   DISPLAY_EN;
    logic [R_W-1:0]         R;
    logic [G_W-1:0]         G;
    logic [B_W-1:0]         B;

    modport master (
        input  PIXEL_DATA,
        output POS_X, POS_Y, REQ_EN, LINE_START, FRAME_START,
        output HSYNC, VSYNC, DISPLAY_EN, R, G, B
    );

    modport slave (
        output PIXEL_DATA,
        input  POS_X, POS_Y, REQ_EN, LINE_START, FRAME_START,
        input  HSYNC, VSYNC, DISPLAY_EN, R, G, B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-pipeline latency compensation.
// Coordinates are issued PIPE_LAT cycles ahead of sync/colour so the upstream pixel source has
// PIPE_LAT-1 cycles to return PIXEL_DATA for each request.
// Ports:
//   FCLK   pixel clock, rising edge
//   RST_N  synchronous active-low reset
//   bus    vga_timing_gen_if.master (coordinates, strobes, sync, DE, colour; PIXEL_DATA in)
// The interface instance must use the same CNT_W/R_W/G_W/B_W as this module.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned R_W      = 3,
    parameter int unsigned G_W      = 3,
    parameter int unsigned B_W      = 2
) (
    input  logic             FCLK,
    input  logic             RST_N,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PIX_W   = R_W + G_W + B_W;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             req_en;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_pre;

    // Stage k holds the raw flags of the counter state k cycles ago.
    logic [PIPE_LAT:1] de_q;
    logic [PIPE_LAT:1] hs_q;
    logic [PIPE_LAT:1] vs_q;
    logic [PIX_W-1:0]  rgb_q;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        req_en = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    // The colour register is itself the last pipeline stage, so it keys off the DE that is one
    // stage short of the output; with PIPE_LAT=1 that is the undelayed request flag.
    if (PIPE_LAT == 1) begin : g_de_pre_direct
        assign de_pre = req_en;
    end else begin : g_de_pre_staged
        assign de_pre = de_q[PIPE_LAT-1];
    end

    always_ff @(posedge FCLK) begin
        if (!RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
            de_q  <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
            rgb_q <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
            de_q[1] <= req_en;
            hs_q[1] <= hs_raw;
            vs_q[1] <= vs_raw;
            for (int unsigned k = 2; k <= PIPE_LAT; k++) begin
                de_q[k] <= de_q[k-1];
                hs_q[k] <= hs_q[k-1];
                vs_q[k] <= vs_q[k-1];
            end
            rgb_q <= de_pre ? bus.PIXEL_DATA : '0;
        end
    end

    assign bus.POS_X       = h_cnt;
    assign bus.POS_Y       = v_cnt;
    assign bus.REQ_EN      = req_en;
    assign bus.LINE_START  = (h_cnt == '0);
    assign bus.FRAME_START = (h_cnt == '0) && (v_cnt == '0);
    // Cleared stages read as the inactive level for either polarity.
    assign bus.HSYNC       = hs_q[PIPE_LAT] ^ ~H_POL;
    assign bus.VSYNC       = vs_q[PIPE_LAT] ^ ~V_POL;
    assign bus.DISPLAY_EN  = de_q[PIPE_LAT];
    assign bus.R           = rgb_q[PIX_W-1 -: R_W];
    assign bus.G           = rgb_q[G_W+B_W-1 -: G_W];
    assign bus.B           = rgb_q[B_W-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Several small-mode builds run side by side on one clock
// and one reset: latency 2 (main), latency 1, latency 4, active-low sync, and zero-width porches.
// Expected values come from a time-indexed model: the raster position of cycle c is derived from
// c with division/modulo, and each delayed output at cycle n is the flag of cycle n-PIPE_LAT.
module tb_vga_timing_gen;
    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
    } mode_t;

    localparam mode_t M_SMALL = '{8, 2, 3, 3, 4, 1, 2, 1};
    localparam mode_t M_ZP    = '{8, 0, 3, 5, 4, 0, 2, 2};
    localparam int    HIST    = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix;
    logic [7:0] pd_hist [HIST];
    int         n;
    bit         pd_rand;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(5)) b_main ();
    vga_timing_gen_if #(.CNT_W(5)) b_l1 ();
    vga_timing_gen_if #(.CNT_W(5)) b_l4 ();
    vga_timing_gen_if #(.CNT_W(5)) b_neg ();
    vga_timing_gen_if #(.CNT_W(5)) b_zp ();

    assign b_main.PIXEL_DATA = pix;
    assign b_l1.PIXEL_DATA   = pix;
    assign b_l4.PIXEL_DATA   = pix;
    assign b_neg.PIXEL_DATA  = pix;
    assign b_zp.PIXEL_DATA   = pix;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .PIPE_LAT(2), .CNT_W(5))
        u_main (.FCLK(clk), .RST_N(rst_n), .bus(b_main));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .PIPE_LAT(1), .CNT_W(5))
        u_l1 (.FCLK(clk), .RST_N(rst_n), .bus(b_l1));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .PIPE_LAT(4), .CNT_W(5))
        u_l4 (.FCLK(clk), .RST_N(rst_n), .bus(b_l4));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .PIPE_LAT(2), .CNT_W(5))
        u_neg (.FCLK(clk), .RST_N(rst_n), .bus(b_neg));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(5), .V_ACTIVE(4), .V_FP(0),
        .V_SYNC(2), .V_BP(2), .PIPE_LAT(2), .CNT_W(5))
        u_zp (.FCLK(clk), .RST_N(rst_n), .bus(b_zp));

    // ---------------- reference model ----------------
    function automatic int m_h(mode_t m, int c);
        return c % (m.ha + m.hfp + m.hsw + m.hbp);
    endfunction

    function automatic int m_v(mode_t m, int c);
        return (c / (m.ha + m.hfp + m.hsw + m.hbp)) % (m.va + m.vfp + m.vsw + m.vbp);
    endfunction

    function automatic bit m_de(mode_t m, int c);
        return (m_h(m, c) < m.ha) && (m_v(m, c) < m.va);
    endfunction

    function automatic bit m_hs(mode_t m, int c);
        int h = m_h(m, c);
        return (h >= m.ha + m.hfp) && (h < m.ha + m.hfp + m.hsw);
    endfunction

    function automatic bit m_vs(mode_t m, int c);
        int v = m_v(m, c);
        return (v >= m.va + m.vfp) && (v < m.va + m.vfp + m.vsw);
    endfunction

    function automatic bit exp_de(mode_t m, int lat, int c);
        return (c >= lat) ? m_de(m, c - lat) : 1'b0;
    endfunction

    function automatic bit exp_hs(mode_t m, int lat, bit pol, int c);
        bit raw = (c >= lat) ? m_hs(m, c - lat) : 1'b0;
        return raw == pol;
    endfunction

    function automatic bit exp_vs(mode_t m, int lat, bit pol, int c);
        bit raw = (c >= lat) ? m_vs(m, c - lat) : 1'b0;
        return raw == pol;
    endfunction

    function automatic logic [7:0] exp_rgb(mode_t m, int lat, int c);
        if (c >= lat && m_de(m, c - lat)) return pd_hist[(c - 1) % HIST];
        return 8'h00;
    endfunction

    // ---------------- stimulus ----------------
    // Pattern mode returns {x[2:0], y[2:0], 2'b01} for the position requested one cycle earlier.
    task automatic set_pix();
        if (pd_rand) begin
            pix = 8'($urandom);
        end else if (n == 0) begin
            pix = 8'h00;
        end else begin
            pix = {3'(m_h(M_SMALL, n - 1)), 3'(m_v(M_SMALL, n - 1)), 2'b01};
        end
        pd_hist[n % HIST] = pix;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        set_pix();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset(int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({b_main.POS_Y, b_main.POS_X} !== 10'd0) begin
                $display("FAIL reset_pos: got %0h want 0", {b_main.POS_Y, b_main.POS_X});
            end else passes++;
            checks++;
            if ({b_main.HSYNC, b_main.VSYNC, b_main.DISPLAY_EN} !== 3'b000) begin
                $display("FAIL reset_sync_de: got %b want 000",
                         {b_main.HSYNC, b_main.VSYNC, b_main.DISPLAY_EN});
            end else passes++;
            checks++;
            if ({b_main.R, b_main.G, b_main.B} !== 8'h00) begin
                $display("FAIL reset_rgb: got %0h want 0", {b_main.R, b_main.G, b_main.B});
            end else passes++;
            checks++;
            if ({b_neg.HSYNC, b_neg.VSYNC} !== 2'b11) begin
                $display("FAIL reset_neg_sync: got %b want 11", {b_neg.HSYNC, b_neg.VSYNC});
            end else passes++;
        end
        rst_n = 1'b1;
        n = 0;
        set_pix();
    endtask

    task automatic test_timing();
        int fs_cnt = 0;
        pd_rand = 1'b0;
        for (int i = 0; i < 129; i++) begin
            checks++;
            if (b_main.FRAME_START !== (n % 128 == 0)) begin
                $display("FAIL frame_start n=%0d: got %b want %b", n, b_main.FRAME_START,
                         n % 128 == 0);
            end else passes++;
            checks++;
            if (b_main.LINE_START !== (n % 16 == 0)) begin
                $display("FAIL line_start n=%0d: got %b want %b", n, b_main.LINE_START,
                         n % 16 == 0);
            end else passes++;
            checks++;
            if ({b_main.POS_Y, b_main.POS_X} !== {5'((n / 16) % 8), 5'(n % 16)}) begin
                $display("FAIL pos n=%0d: got y=%0d x=%0d want y=%0d x=%0d", n, b_main.POS_Y,
                         b_main.POS_X, (n / 16) % 8, n % 16);
            end else passes++;
            checks++;
            if (b_main.REQ_EN !== m_de(M_SMALL, n)) begin
                $display("FAIL req_en n=%0d: got %b want %b", n, b_main.REQ_EN, m_de(M_SMALL, n));
            end else passes++;
            checks++;
            if ({b_main.HSYNC, b_main.VSYNC, b_main.DISPLAY_EN} !==
                {exp_hs(M_SMALL, 2, 1'b1, n), exp_vs(M_SMALL, 2, 1'b1, n), exp_de(M_SMALL, 2, n)})
            begin
                $display("FAIL sync_de n=%0d: got %b want %b", n,
                         {b_main.HSYNC, b_main.VSYNC, b_main.DISPLAY_EN},
                         {exp_hs(M_SMALL, 2, 1'b1, n), exp_vs(M_SMALL, 2, 1'b1, n),
                          exp_de(M_SMALL, 2, n)});
            end else passes++;
            fs_cnt += int'(b_main.FRAME_START);
            tick();
        end
        checks++;
        if (fs_cnt !== 2) $display("FAIL frame_start_count: got %0d want 2", fs_cnt);
        else passes++;
    endtask

    task automatic test_pattern();
        pd_rand = 1'b0;
        for (int i = 0; i < 128; i++) begin
            checks++;
            if ({b_main.R, b_main.G, b_main.B} !== exp_rgb(M_SMALL, 2, n)) begin
                $display("FAIL pattern_rgb n=%0d: got %0h want %0h", n,
                         {b_main.R, b_main.G, b_main.B}, exp_rgb(M_SMALL, 2, n));
            end else passes++;
            if (b_main.DISPLAY_EN === 1'b0) begin
                checks++;
                if ({b_main.R, b_main.G, b_main.B} !== 8'h00) begin
                    $display("FAIL blank_rgb n=%0d: got %0h want 0", n,
                             {b_main.R, b_main.G, b_main.B});
                end else passes++;
            end
            if ((n - 2) % 128 == 37) begin
                checks++;
                if ({b_main.R, b_main.G, b_main.B, b_main.DISPLAY_EN} !==
                    {3'd5, 3'd2, 2'd1, 1'b1}) begin
                    $display("FAIL line2_px5: got r=%0d g=%0d b=%0d de=%b want 5 2 1 1",
                             b_main.R, b_main.G, b_main.B, b_main.DISPLAY_EN);
                end else passes++;
            end
            tick();
        end
    endtask

    task automatic test_random_pixels();
        pd_rand = 1'b1;
        for (int i = 0; i < 128; i++) begin
            checks++;
            if ({b_main.R, b_main.G, b_main.B} !== exp_rgb(M_SMALL, 2, n)) begin
                $display("FAIL rand_rgb_main n=%0d: got %0h want %0h", n,
                         {b_main.R, b_main.G, b_main.B}, exp_rgb(M_SMALL, 2, n));
            end else passes++;
            checks++;
            if ({b_l4.R, b_l4.G, b_l4.B} !== exp_rgb(M_SMALL, 4, n)) begin
                $display("FAIL rand_rgb_l4 n=%0d: got %0h want %0h", n,
                         {b_l4.R, b_l4.G, b_l4.B}, exp_rgb(M_SMALL, 4, n));
            end else passes++;
            checks++;
            if ({b_zp.R, b_zp.G, b_zp.B} !== exp_rgb(M_ZP, 2, n)) begin
                $display("FAIL rand_rgb_zp n=%0d: got %0h want %0h", n,
                         {b_zp.R, b_zp.G, b_zp.B}, exp_rgb(M_ZP, 2, n));
            end else passes++;
            tick();
        end
    endtask

    task automatic test_latency();
        pd_rand = 1'b1;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if ({b_l1.DISPLAY_EN, b_l1.HSYNC, b_l1.VSYNC} !==
                {exp_de(M_SMALL, 1, n), exp_hs(M_SMALL, 1, 1'b1, n), exp_vs(M_SMALL, 1, 1'b1, n)})
            begin
                $display("FAIL lat1_de_sync n=%0d: got %b want %b", n,
                         {b_l1.DISPLAY_EN, b_l1.HSYNC, b_l1.VSYNC},
                         {exp_de(M_SMALL, 1, n), exp_hs(M_SMALL, 1, 1'b1, n),
                          exp_vs(M_SMALL, 1, 1'b1, n)});
            end else passes++;
            checks++;
            if ({b_l1.R, b_l1.G, b_l1.B} !== exp_rgb(M_SMALL, 1, n)) begin
                $display("FAIL lat1_rgb n=%0d: got %0h want %0h", n,
                         {b_l1.R, b_l1.G, b_l1.B}, exp_rgb(M_SMALL, 1, n));
            end else passes++;
            checks++;
            if ({b_l4.DISPLAY_EN, b_l4.HSYNC, b_l4.VSYNC} !==
                {exp_de(M_SMALL, 4, n), exp_hs(M_SMALL, 4, 1'b1, n), exp_vs(M_SMALL, 4, 1'b1, n)})
            begin
                $display("FAIL lat4_de_sync n=%0d: got %b want %b", n,
                         {b_l4.DISPLAY_EN, b_l4.HSYNC, b_l4.VSYNC},
                         {exp_de(M_SMALL, 4, n), exp_hs(M_SMALL, 4, 1'b1, n),
                          exp_vs(M_SMALL, 4, 1'b1, n)});
            end else passes++;
            tick();
        end
    endtask

    task automatic test_polarity();
        for (int i = 0; i < 128; i++) begin
            checks++;
            if ({b_neg.HSYNC, b_neg.VSYNC} !==
                {exp_hs(M_SMALL, 2, 1'b0, n), exp_vs(M_SMALL, 2, 1'b0, n)}) begin
                $display("FAIL neg_sync n=%0d: got %b want %b", n, {b_neg.HSYNC, b_neg.VSYNC},
                         {exp_hs(M_SMALL, 2, 1'b0, n), exp_vs(M_SMALL, 2, 1'b0, n)});
            end else passes++;
            tick();
        end
    endtask

    task automatic test_zero_porch();
        for (int i = 0; i < 128; i++) begin
            checks++;
            if ({b_zp.HSYNC, b_zp.VSYNC, b_zp.DISPLAY_EN} !==
                {exp_hs(M_ZP, 2, 1'b1, n), exp_vs(M_ZP, 2, 1'b1, n), exp_de(M_ZP, 2, n)}) begin
                $display("FAIL zp_sync_de n=%0d: got %b want %b", n,
                         {b_zp.HSYNC, b_zp.VSYNC, b_zp.DISPLAY_EN},
                         {exp_hs(M_ZP, 2, 1'b1, n), exp_vs(M_ZP, 2, 1'b1, n), exp_de(M_ZP, 2, n)});
            end else passes++;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while ((n % 128) != 90 && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if ({b_main.POS_Y, b_main.POS_X} !== {5'd5, 5'd10}) begin
            $display("FAIL midreset_arm: got y=%0d x=%0d want y=5 x=10", b_main.POS_Y,
                     b_main.POS_X);
        end else passes++;
        test_reset(3);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (b_main.FRAME_START !== (n == 0)) begin
                $display("FAIL midreset_frame_start n=%0d: got %b want %b", n,
                         b_main.FRAME_START, n == 0);
            end else passes++;
            checks++;
            if ({b_main.POS_Y, b_main.POS_X} !== {5'((n / 16) % 8), 5'(n % 16)}) begin
                $display("FAIL midreset_pos n=%0d: got y=%0d x=%0d want y=%0d x=%0d", n,
                         b_main.POS_Y, b_main.POS_X, (n / 16) % 8, n % 16);
            end else passes++;
            checks++;
            if ({b_main.HSYNC, b_main.VSYNC, b_l4.HSYNC, b_l4.VSYNC} !==
                {exp_hs(M_SMALL, 2, 1'b1, n), exp_vs(M_SMALL, 2, 1'b1, n),
                 exp_hs(M_SMALL, 4, 1'b1, n), exp_vs(M_SMALL, 4, 1'b1, n)}) begin
                $display("FAIL midreset_sync n=%0d: got %b want %b", n,
                         {b_main.HSYNC, b_main.VSYNC, b_l4.HSYNC, b_l4.VSYNC},
                         {exp_hs(M_SMALL, 2, 1'b1, n), exp_vs(M_SMALL, 2, 1'b1, n),
                          exp_hs(M_SMALL, 4, 1'b1, n), exp_vs(M_SMALL, 4, 1'b1, n)});
            end else passes++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        pix     = 8'h00;
        n       = 0;
        pd_rand = 1'b0;
        test_reset(3);
        test_timing();
        test_pattern();
        test_random_pixels();
        test_latency();
        test_polarity();
        test_zero_porch();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
